// File: rtl/riscv_defs.sv
// Shared RV32 definitions: funct3 size codes, opcodes and LSU state encoding.
// Also holds the access classification helpers used by the load/store unit.
package riscv_defs;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Size lives in funct3[1:0]; signedness in funct3[2] does not affect alignment.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane steering: store strobes/replicated data, and load
// byte/halfword selection with sign or zero extension.
module lsu_align
  import riscv_defs::*;
(
  input  logic        is_store,
  input  logic [2:0]  st_f3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_f3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wstrb = 4'b0000;
    wdata = 32'd0;
    if (is_store) begin
      case (st_f3)
        F3_B: begin
          wstrb = 4'b0001 << st_off;
          wdata = {4{st_data[7:0]}};
        end
        F3_H: begin
          wstrb = st_off[1] ? 4'b1100 : 4'b0011;
          wdata = {2{st_data[15:0]}};
        end
        F3_W: begin
          wstrb = 4'b1111;
          wdata = st_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_byte = 8'd0;
    case (ld_off)
      2'd0: ld_byte = rdata[7:0];
      2'd1: ld_byte = rdata[15:8];
      2'd2: ld_byte = rdata[23:16];
      2'd3: ld_byte = rdata[31:24];
      default: ;
    endcase
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_f3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 memory-access stage: classifies load/store, runs a req/ack transaction
// with timeout, and returns the extended load result.
module load_store_unit
  import riscv_defs::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_valid,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              misalign_err,
  output logic              illegal_err,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       lat_f3;
  logic [1:0]       lat_off;
  logic [3:0]       wstrb;
  logic [31:0]      wdata;
  logic [31:0]      ld_data;
  logic             legal, misal, accept;

  assign legal  = f3_legal(is_store, funct3);
  assign misal  = f3_misaligned(funct3, addr[1:0]);
  assign accept = (state == LSU_IDLE) && lsu_valid && legal && !misal;
  assign stall  = (state == LSU_REQ) || accept;

  lsu_align u_align (
    .is_store (is_store),
    .st_f3    (funct3),
    .st_off   (addr[1:0]),
    .st_data  (store_data),
    .wstrb    (wstrb),
    .wdata    (wdata),
    .ld_f3    (lat_f3),
    .ld_off   (lat_off),
    .rdata    (mem_rdata),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= LSU_IDLE;
      cnt          <= '0;
      lat_f3       <= 3'd0;
      lat_off      <= 2'd0;
      done         <= 1'b0;
      load_data    <= 32'd0;
      misalign_err <= 1'b0;
      illegal_err  <= 1'b0;
      bus_err      <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wstrb    <= 4'd0;
      mem_wdata    <= 32'd0;
    end else begin
      done         <= 1'b0;
      misalign_err <= 1'b0;
      illegal_err  <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (lsu_valid) begin
            // Illegal funct3 outranks misalignment; neither touches memory.
            if (!legal) illegal_err <= 1'b1;
            else if (misal) misalign_err <= 1'b1;
            else begin
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
              mem_wstrb <= wstrb;
              mem_wdata <= wdata;
              lat_f3    <= funct3;
              lat_off   <= addr[1:0];
              cnt       <= '0;
              state     <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= LSU_RESP;
            if (!mem_we) load_data <= ld_data;
          end else if (cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= LSU_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LSU_RESP: state <= LSU_IDLE;
        default:  state <= LSU_IDLE;
      endcase
    end
  end

endmodule
